// File: rtl/perf_monitor.sv
// Performance monitor: one free-running cycle counter plus NUM_EVT event counters,
// with wrap/saturate/freeze overflow policies and a snapshot shadow bank.
module perf_monitor #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned NUM_EVT   = 4,
    parameter int unsigned MODE      = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_EVT-1:0]             evt_in,
    input  logic                           enable,
    input  logic                           clear,
    input  logic                           snap,
    input  logic [$clog2(NUM_EVT+1)-1:0]   sel,
    output logic [CNT_WIDTH-1:0]           out1,
    output logic [CNT_WIDTH-1:0]           out2,
    output logic [NUM_EVT:0]               ovf,
    output logic                           snap_valid,
    output logic [1:0]                     state
);

    localparam int unsigned NumCnt = NUM_EVT + 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFrozen = 2'd2
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt    [NumCnt];
    logic [CNT_WIDTH-1:0] r_shadow [NumCnt];
    logic [CNT_WIDTH-1:0] w_cnt_next [NumCnt];
    logic [NUM_EVT:0]     r_ovf;
    logic [NUM_EVT:0]     w_inc;
    logic [NUM_EVT:0]     w_ovf_evt;
    logic                 r_snap_valid;

    // Index 0 is the cycle counter, which counts unconditionally while running.
    always_comb begin
        w_inc     = {evt_in, 1'b1};
        w_ovf_evt = '0;
        for (int k = 0; k < NumCnt; k++) begin
            w_cnt_next[k] = r_cnt[k];
            if ((r_state == StRun) && w_inc[k]) begin
                if (&r_cnt[k]) begin
                    w_ovf_evt[k]  = 1'b1;
                    w_cnt_next[k] = (MODE == 0) ? '0 : r_cnt[k];
                end else begin
                    w_cnt_next[k] = r_cnt[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Overflow-driven freeze wins over a simultaneous enable drop; clear wins over all.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (enable) w_state_next = StRun;
            end
            StRun: begin
                if ((MODE == 2) && (|w_ovf_evt)) w_state_next = StFrozen;
                else if (!enable)                w_state_next = StIdle;
            end
            StFrozen: w_state_next = StFrozen;
            default:  w_state_next = StIdle;
        endcase
        if (clear) w_state_next = StIdle;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_ovf        <= '0;
            r_snap_valid <= 1'b0;
            for (int k = 0; k < NumCnt; k++) begin
                r_cnt[k]    <= '0;
                r_shadow[k] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            // Shadows take the pre-update values and ignore clear.
            if (snap) begin
                r_snap_valid <= 1'b1;
                for (int k = 0; k < NumCnt; k++) r_shadow[k] <= r_cnt[k];
            end
            if (clear) begin
                r_ovf <= '0;
                for (int k = 0; k < NumCnt; k++) r_cnt[k] <= '0;
            end else begin
                r_ovf <= r_ovf | w_ovf_evt;
                for (int k = 0; k < NumCnt; k++) r_cnt[k] <= w_cnt_next[k];
            end
        end
    end

    always_comb begin
        out2 = '0;
        if (32'(sel) <= NUM_EVT) out2 = r_shadow[sel];
    end

    assign out1       = r_cnt[0];
    assign ovf        = r_ovf;
    assign snap_valid = r_snap_valid;
    assign state      = r_state;

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 The module SHALL have parameter CNT_WIDTH, default 32, which sets the width of each counter.
REQ-002 The module SHALL have parameter NUM_EVT, default 4, which sets the number of event channels.
REQ-003 The module SHALL have parameter MODE, default 0, which sets overflow behaviour: 0 = wrap, 1 = saturate, 2 = freeze-all.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port evt_in, input, NUM_EVT bits: per-channel event pulses (retire, stall, flush, ...), one increment per cycle high.
REQ-007 The module SHALL have port enable, input, 1 bit: global count enable.
REQ-008 The module SHALL have port clear, input, 1 bit: synchronous clear of counters and overflow flags.
REQ-009 The module SHALL have port snap, input, 1 bit: snapshot request.
REQ-010 The module SHALL have port sel, input, $clog2(NUM_EVT+1) bits: snapshot read select (0 = cycle counter, k = event channel k-1).
REQ-011 The module SHALL have port out1, output, CNT_WIDTH bits: live cycle counter.
REQ-012 The module SHALL have port out2, output, CNT_WIDTH bits: snapshot value selected by sel.
REQ-013 The module SHALL have port ovf, output, NUM_EVT+1 bits: sticky overflow flags (bit 0 = cycle counter, bit k = channel k-1).
REQ-014 The module SHALL have port snap_valid, output, 1 bit: high once at least one snapshot has been taken.
REQ-015 The module SHALL have port state, output, 2 bits: FSM state, encoded IDLE=0, RUN=1, FROZEN=2.

Function
REQ-016 The module SHALL implement a 3-state FSM: IDLE (paused), RUN (counting) and FROZEN (halted after overflow, MODE 2 only).
REQ-017 FSM transitions SHALL be: IDLE->RUN when enable=1; RUN->IDLE when enable=0; RUN->FROZEN on any overflow event when MODE=2; FROZEN->IDLE only on clear=1; in every state, clear=1 forces next state IDLE.
REQ-018 In RUN, the cycle counter SHALL increment by 1 every cycle, and event counter k SHALL increment by 1 in each cycle that evt_in[k]=1.
REQ-019 In IDLE and FROZEN, all counters SHALL hold their values.
REQ-020 The cycle in which enable first rises SHALL NOT be counted; counting SHALL begin in the cycle after IDLE->RUN.
REQ-021 Overflow SHALL be defined as an increment applied to a counter at all-ones, and SHALL set that counter's ovf bit, which stays set until clear or reset.
REQ-022 On overflow with MODE 0, the counter SHALL wrap to 0.
REQ-023 On overflow with MODE 1 or MODE 2, the counter SHALL stay at all-ones.
REQ-024 With MODE 2, the module SHALL enter FROZEN on the edge after the overflowing increment; increments in that same cycle on other channels SHALL still apply.
REQ-025 Simultaneous overflows on several counters SHALL set all corresponding ovf bits in the same cycle.
REQ-026 clear SHALL take priority over increments: on clear=1 all counters and ovf SHALL be 0 next cycle and no increment from that cycle SHALL survive.
REQ-027 snap=1 SHALL copy all NUM_EVT+1 counter registers, as held before this cycle's update, into shadow registers at the edge.
REQ-028 out2 SHALL be a combinational read of shadow[sel], reflecting a new snapshot in the cycle after snap.
REQ-029 snap and clear in the same cycle SHALL capture the pre-clear values; shadow registers SHALL NOT be affected by clear.
REQ-030 snap_valid SHALL rise on the edge that takes the first snapshot and SHALL stay high until reset.
REQ-031 A sel value greater than NUM_EVT SHALL drive out2=0.
REQ-032 Latency SHALL be: out1 updates 1 cycle after the counted cycle; ovf updates on the same edge as the overflowing increment.

Reset
REQ-033 When reset_n=0 at a rising edge, the module SHALL force state=IDLE and all counters, shadow registers, ovf and snap_valid to 0; consequently out1=0 and out2=0.
REQ-034 Reset SHALL override clear, snap and enable, including when asserted mid-count or while FROZEN.
REQ-035 Reset SHALL take effect only on a clock edge; there is no asynchronous path.

Verification
REQ-036 The bench SHALL cover: CNT_WIDTH=8, MODE 0, reset then enable=1 for 10 cycles with evt_in[0]=1 on 3 of them -> out1=10, snap then sel=1 gives out2=3, snap_valid=1.
REQ-037 The bench SHALL cover: CNT_WIDTH=8, MODE 0, 256 cycles in RUN -> out1 wraps to 0, ovf[0]=1 and stays 1 until clear.
REQ-038 The bench SHALL cover: CNT_WIDTH=8, MODE 1, evt_in[1] held high for 300 RUN cycles -> counter 1 = 255, ovf[2]=1, out1=255 (saturated).
REQ-039 The bench SHALL cover: CNT_WIDTH=8, MODE 2, cycle counter reaches 255 and overflows -> state=2 next cycle, all counters frozen; clear -> IDLE, all counters 0, ovf=0.
REQ-040 The bench SHALL cover: snap and clear in the same cycle with out1=42 -> next cycle out1=0, sel=0 gives out2=42.
REQ-041 The bench SHALL cover: reset_n=0 for 1 cycle mid-RUN with out1=100 and snap_valid=1 -> out1=0, out2=0, ovf=0, snap_valid=0, state=IDLE.
